// File: rtl/fifo_pkg.sv
// Shared FIFO parameters used by the FIFO and its write-side clients.
package fifo_pkg;
    localparam int unsigned DATA_WIDTH = 8;
endpackage

// File: rtl/fifo_push_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO push port among NUM_REQ
// valid/ready producers, with optional grant locking for bursts.
module fifo_push_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   lock_id;
    logic [CW-1:0]   beat_cnt;

    logic [IW:0]     scan_sum;
    logic [IW-1:0]   idle_id;
    logic            idle_found;
    logic [IW-1:0]   gid;
    logic            gv;
    logic            sel_valid;
    logic            sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic            xfer;
    logic            burst_end;
    logic [IW-1:0]   next_ptr;

    // Round-robin scan starting at rr_ptr; wrap uses an explicit compare.
    always_comb begin
        idle_found = 1'b0;
        idle_id    = '0;
        scan_sum   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            scan_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (scan_sum >= (IW+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (IW+1)'(NUM_REQ);
            end
            if (!idle_found && req_valid[IW'(scan_sum)]) begin
                idle_found = 1'b1;
                idle_id    = IW'(scan_sum);
            end
        end
    end

    // Grant selection, transfer qualification and output steering.
    always_comb begin
        gv        = (state == LOCK) || idle_found;
        gid       = (state == LOCK) ? lock_id : idle_id;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gid == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        xfer      = !rst && gv && sel_valid && !fifo_full;
        burst_end = sel_last || (beat_cnt == CW'(MAX_BURST - 1));
        next_ptr  = (gid == IW'(NUM_REQ - 1)) ? '0 : gid + IW'(1);

        req_ready    = '0;
        fifo_wr_en   = xfer;
        fifo_wr_data = xfer ? sel_data : '0;
        grant_valid  = !rst && gv;
        grant_id     = (!rst && gv) ? gid : '0;
        if (xfer) begin
            req_ready[gid] = 1'b1;
        end
    end

    // Arbitration state only moves on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_id  <= '0;
            beat_cnt <= '0;
        end else if (xfer) begin
            if (burst_end) begin
                state    <= IDLE;
                rr_ptr   <= next_ptr;
                beat_cnt <= '0;
            end else if (state == IDLE) begin
                state    <= LOCK;
                lock_id  <= gid;
                beat_cnt <= CW'(1);
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: expected pushes are queued by the
// stimulus and popped by a monitor whenever the arbiter writes the FIFO.
module tb_fifo_push_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = fifo_pkg::DATA_WIDTH;
    localparam int unsigned MB = 4;
    localparam int unsigned IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;

    fifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q[$];
    int   seq[NR];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every FIFO push must match the oldest queued beat.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected: got data %0d with no beat queued", fifo_wr_data);
            end else begin
                e = q.pop_front();
                if (fifo_wr_data !== e.data || grant_id !== e.id) begin
                    errors++;
                    $display("FAIL push_data: got id %0d data %0d expected id %0d data %0d",
                             grant_id, fifo_wr_data, e.id, e.data);
                end
            end
        end
    end

    // One clock of stimulus with hand-computed grant and push expectations.
    task automatic step(input logic r, input logic [NR-1:0] v, input logic [NR-1:0] l,
                        input logic f, input logic p, input logic gv, input int gid);
        exp_t e;
        rst       = r;
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        for (int i = 0; i < int'(NR); i++) begin
            req_data[i*DW +: DW] = DW'(i*16 + seq[i]);
        end
        if (p) begin
            e.id   = IW'(gid);
            e.data = DW'(gid*16 + seq[gid]);
            q.push_back(e);
        end
        @(negedge clk);
        chk("fifo_wr_en", int'(fifo_wr_en), int'(p));
        chk("grant_valid", int'(grant_valid), int'(gv));
        chk("grant_id", int'(grant_id), gid);
        chk("req_ready", int'(req_ready), p ? (1 << gid) : 0);
        if (!p) chk("wr_data_idle", int'(fifo_wr_data), 0);
        if (p) seq[gid]++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) seq[i] = 0;
        rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;

        // reset: all outputs forced low even with producers valid
        step(1, 4'hF, 4'hF, 0, 0, 0, 0);
        step(1, 4'hF, 4'hF, 0, 0, 0, 0);

        // fairness
        for (int i = 0; i < 8; i++) step(0, 4'hF, 4'hF, 0, 1, 1, i % 4);

        // burst lock on producer 2 (rr_ptr brought to 2 first)
        step(0, 4'h3, 4'hF, 0, 1, 1, 0);
        step(0, 4'h3, 4'hF, 0, 1, 1, 1);
        step(0, 4'hF, 4'b1011, 0, 1, 1, 2);
        step(0, 4'hF, 4'b1011, 0, 1, 1, 2);
        step(0, 4'hF, 4'hF, 0, 1, 1, 2);
        step(0, 4'hF, 4'hF, 0, 1, 1, 3);

        // truncation of producer 1's 6-beat burst at MAX_BURST
        step(0, 4'h1, 4'hF, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 4'h3, 4'b1101, 0, 1, 1, 1);
        step(0, 4'h3, 4'b1101, 0, 1, 1, 0);
        step(0, 4'h3, 4'b1101, 0, 1, 1, 1);
        step(0, 4'h3, 4'hF, 0, 1, 1, 1);

        // full stall mid-burst on producer 2
        step(0, 4'h4, 4'h0, 0, 1, 1, 2);
        step(0, 4'h4, 4'h0, 0, 1, 1, 2);
        for (int i = 0; i < 5; i++) step(0, 4'hF, 4'h0, 1, 0, 1, 2);
        step(0, 4'h4, 4'h0, 0, 1, 1, 2);
        step(0, 4'h4, 4'h0, 0, 1, 1, 2);
        step(0, 4'h5, 4'hF, 0, 1, 1, 0);

        // locked producer bubble
        step(0, 4'h3, 4'b1101, 0, 1, 1, 1);
        step(0, 4'b1101, 4'hF, 0, 0, 1, 1);
        step(0, 4'b1101, 4'hF, 0, 0, 1, 1);
        step(0, 4'h2, 4'hF, 0, 1, 1, 1);
        step(0, 4'h3, 4'hF, 0, 1, 1, 0);

        // reset mid-burst on producer 3
        step(0, 4'h8, 4'h0, 0, 1, 1, 3);
        step(1, 4'h8, 4'h0, 0, 0, 0, 0);
        step(0, 4'h9, 4'hF, 0, 1, 1, 0);
        step(0, 4'h8, 4'hF, 0, 1, 1, 3);

        // idle
        step(0, 4'h0, 4'h0, 0, 0, 0, 0);

        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
